mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory between the pipelined RISC-V core's instruction fetch (IF) and its load/store stage (MEM).
- Issues one transaction at a time over a req/ready handshake and returns the read data to the requester that owns it.
- Drives per-requester stall signals that the core ORs into its existing pipeline stall logic.
- Data side has priority; a starvation counter bounds how long a fetch can wait; a watchdog flags a hung memory.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared memory port.
// master is the arbiter's view; slave is the core/memory side that drives the requests.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_type;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_type;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        err;

    modport master (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_valid, if_stall,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_type,
        output dm_rdata, dm_valid, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
        input  mem_ready, mem_rdata,
        output err
    );

    modport slave (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_valid, if_stall,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_type,
        input  dm_rdata, dm_valid, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
        output mem_ready, mem_rdata,
        input  err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, one transaction
// at a time, with data-side priority bounded by a fetch starvation counter and a hang watchdog.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, ERR} state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
    localparam logic [7:0] WAIT_MAX   = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        discard_q, discard_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  mem_type_q, mem_type_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_valid_q, dm_valid_d;

    logic if_elig, dm_elig;

    // A requester whose completion pulse is still high has not yet retired its request.
    assign if_elig = bus.if_req & ~if_valid_q;
    assign dm_elig = bus.dm_req & ~dm_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            discard_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_type_q   <= '0;
            if_rdata_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_rdata_q   <= '0;
            dm_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            discard_q    <= discard_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_type_q   <= mem_type_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_valid_q   <= dm_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        discard_d    = discard_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_type_d   = mem_type_q;
        if_rdata_d   = if_rdata_q;
        if_valid_d   = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        dm_valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (dm_elig && !(if_elig && (starve_cnt_q == STARVE_MAX))) begin
                    state_d     = DM_BUSY;
                    wait_cnt_d  = '0;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    mem_type_d  = bus.dm_type;
                    // Only reached with IF waiting while the count is below the limit.
                    if (if_elig) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (if_elig) begin
                    state_d      = IF_BUSY;
                    wait_cnt_d   = '0;
                    starve_cnt_d = '0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    mem_wdata_d  = '0;
                    mem_type_d   = 3'b000;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if ((state_q == IF_BUSY) && bus.if_flush) begin
                    discard_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (state_q == IF_BUSY) begin
                        if (!(discard_q || bus.if_flush)) begin
                            if_valid_d = 1'b1;
                            if_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ERR;
                    wait_cnt_d = WAIT_MAX;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ERR;
            end
        endcase
    end

    assign bus.mem_req   = (state_q == IF_BUSY) || (state_q == DM_BUSY);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_type  = mem_type_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
    assign bus.err       = (state_q == ERR);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each task drives one scenario and checks its
// hand-computed expectations one cycle at a time, 1 ns after the rising edge.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [31:0] last_if_rdata;
    logic [31:0] last_dm_rdata;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(2), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_type = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step(); step();
        total_cnt++;
        if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.err, bus.if_stall, bus.dm_stall, bus.mem_type} !== 10'b0)
            $display("FAIL reset_flags: got %b expected 0", {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.err, bus.if_stall, bus.dm_stall, bus.mem_type});
        else pass_cnt++;
        total_cnt++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== 128'b0)
            $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata});
        else pass_cnt++;
        reset = 0;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.err} !== 2'b00) $display("FAIL reset_release: got %b expected 00", {bus.mem_req, bus.err});
        else pass_cnt++;
        $display("tx reset done");
    endtask

    task automatic test_fetch();
        bus.if_req = 1; bus.if_addr = 32'h10;
        #1;
        total_cnt++;
        if ({bus.if_stall, bus.mem_req} !== 2'b10) $display("FAIL fetch_t_stall: got %b expected 10", {bus.if_stall, bus.mem_req});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.mem_we, bus.mem_type, bus.if_stall} !== 6'b100001) $display("FAIL fetch_issue: got %b expected 100001", {bus.mem_req, bus.mem_we, bus.mem_type, bus.if_stall});
        else pass_cnt++;
        total_cnt++;
        if (bus.mem_addr !== 32'h10) $display("FAIL fetch_addr: got %h expected 00000010", bus.mem_addr);
        else pass_cnt++;
        bus.mem_ready = 1; bus.mem_rdata = 32'h00500093;
        step();
        bus.mem_ready = 0; bus.mem_rdata = 32'hFFFFFFFF;
        total_cnt++;
        if ({bus.if_valid, bus.if_stall, bus.mem_req} !== 3'b100) $display("FAIL fetch_done: got %b expected 100", {bus.if_valid, bus.if_stall, bus.mem_req});
        else pass_cnt++;
        total_cnt++;
        if (bus.if_rdata !== 32'h00500093) $display("FAIL fetch_rdata: got %h expected 00500093", bus.if_rdata);
        else pass_cnt++;
        last_if_rdata = 32'h00500093;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.if_valid} !== 2'b00) $display("FAIL fetch_no_reissue: got %b expected 00", {bus.mem_req, bus.if_valid});
        else pass_cnt++;
        bus.if_req = 0;
        step();
        $display("tx fetch addr=00000010 rdata=%h", bus.if_rdata);
    endtask

    task automatic test_priority();
        bus.if_req = 1; bus.if_addr = 32'h200;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100; bus.dm_type = 3'b010;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.mem_we, bus.mem_type, bus.mem_addr} !== {1'b1, 1'b0, 3'b010, 32'h100})
            $display("FAIL prio_dm_first: got %b_%h expected 1_0_010_00000100", {bus.mem_req, bus.mem_we, bus.mem_type}, bus.mem_addr);
        else pass_cnt++;
        total_cnt++;
        if ({bus.if_stall, bus.dm_stall} !== 2'b11) $display("FAIL prio_stalls: got %b expected 11", {bus.if_stall, bus.dm_stall});
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.mem_req !== 1'b1) $display("FAIL prio_wait: got %b expected 1", bus.mem_req);
        else pass_cnt++;
        bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE0001;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if ({bus.dm_valid, bus.if_valid, bus.mem_req} !== 3'b100 || bus.dm_rdata !== 32'hCAFE0001)
            $display("FAIL prio_dm_done: got %b/%h expected 100/cafe0001", {bus.dm_valid, bus.if_valid, bus.mem_req}, bus.dm_rdata);
        else pass_cnt++;
        last_dm_rdata = 32'hCAFE0001;
        bus.dm_req = 0;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.mem_type} !== 4'b1000 || bus.mem_addr !== 32'h200)
            $display("FAIL prio_if_second: got %b/%h expected 1000/00000200", {bus.mem_req, bus.mem_type}, bus.mem_addr);
        else pass_cnt++;
        step();
        bus.mem_ready = 1; bus.mem_rdata = 32'h11112222;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h11112222)
            $display("FAIL prio_if_done: got %b/%h expected 1/11112222", bus.if_valid, bus.if_rdata);
        else pass_cnt++;
        last_if_rdata = 32'h11112222;
        bus.if_req = 0;
        step();
        $display("tx priority dm=%h if=%h", bus.dm_rdata, bus.if_rdata);
    endtask

    // Both requesters contend from idle; the loser withdraws while the winner is served.
    task automatic contest(input logic exp_dm, input logic [31:0] tag, input int idx);
        logic [31:0] exp_addr;
        exp_addr = exp_dm ? 32'h304 : 32'h300;
        bus.if_req = 1; bus.if_addr = 32'h300;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h304; bus.dm_type = 3'b010;
        step();
        total_cnt++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr)
            $display("FAIL starve_grant%0d: got %b/%h expected 1/%h", idx, bus.mem_req, bus.mem_addr, exp_addr);
        else pass_cnt++;
        if (exp_dm) bus.if_req = 0; else bus.dm_req = 0;
        bus.mem_ready = 1; bus.mem_rdata = tag;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if ({bus.dm_valid, bus.if_valid} !== (exp_dm ? 2'b10 : 2'b01))
            $display("FAIL starve_done%0d: got %b expected %b", idx, {bus.dm_valid, bus.if_valid}, (exp_dm ? 2'b10 : 2'b01));
        else pass_cnt++;
        if (exp_dm) last_dm_rdata = tag; else last_if_rdata = tag;
        bus.if_req = 0; bus.dm_req = 0;
        step(); step();
        $display("tx contest %0d winner=%s tag=%h", idx, exp_dm ? "dm" : "if", tag);
    endtask

    task automatic test_starvation();
        contest(1'b1, 32'hA0000001, 1);
        contest(1'b1, 32'hA0000002, 2);
        contest(1'b0, 32'hA0000003, 3);
        contest(1'b1, 32'hA0000004, 4);
    endtask

    task automatic test_flush();
        bus.if_req = 1; bus.if_addr = 32'h20;
        step();
        total_cnt++;
        if (bus.mem_addr !== 32'h20) $display("FAIL flush_issue: got %h expected 00000020", bus.mem_addr);
        else pass_cnt++;
        bus.if_flush = 1;
        step();
        bus.if_flush = 0;
        total_cnt++;
        if (bus.mem_req !== 1'b1) $display("FAIL flush_no_abort: got %b expected 1", bus.mem_req);
        else pass_cnt++;
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if ({bus.if_valid, bus.mem_req} !== 2'b00 || bus.if_rdata !== last_if_rdata)
            $display("FAIL flush_suppress: got %b/%h expected 00/%h", {bus.if_valid, bus.mem_req}, bus.if_rdata, last_if_rdata);
        else pass_cnt++;
        bus.if_addr = 32'h40;
        step();
        total_cnt++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) $display("FAIL flush_refetch: got %b/%h expected 1/00000040", bus.mem_req, bus.mem_addr);
        else pass_cnt++;
        bus.mem_ready = 1; bus.mem_rdata = 32'h00000013;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h00000013) $display("FAIL flush_refetch_done: got %b/%h expected 1/00000013", bus.if_valid, bus.if_rdata);
        else pass_cnt++;
        last_if_rdata = 32'h00000013;
        bus.if_req = 0;
        step();
        $display("tx flush refetch rdata=%h", bus.if_rdata);
    endtask

    task automatic test_store();
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h8; bus.dm_wdata = 32'h12345678; bus.dm_type = 3'b010;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h8 || bus.mem_wdata !== 32'h12345678)
            $display("FAIL store_issue: got %b/%h/%h expected 11/00000008/12345678", {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        else pass_cnt++;
        bus.dm_wdata = 32'hFFFFFFFF; bus.dm_addr = 32'hC; bus.if_flush = 1;
        step();
        bus.if_flush = 0;
        total_cnt++;
        if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h8 || bus.mem_wdata !== 32'h12345678)
            $display("FAIL store_stable: got %b/%h/%h expected 11/00000008/12345678", {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        else pass_cnt++;
        bus.mem_ready = 1; bus.mem_rdata = 32'hBADBAD00;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== last_dm_rdata)
            $display("FAIL store_done: got %b/%h expected 1/%h", bus.dm_valid, bus.dm_rdata, last_dm_rdata);
        else pass_cnt++;
        bus.dm_req = 0; bus.dm_we = 0;
        step();
        $display("tx store addr=00000008 wdata=12345678");
    endtask

    task automatic test_watchdog();
        bus.if_req = 1; bus.if_addr = 32'h50;
        step();
        for (int i = 0; i < 7; i++) step();
        total_cnt++;
        if ({bus.mem_req, bus.err} !== 2'b10) $display("FAIL wdog_busy8: got %b expected 10", {bus.mem_req, bus.err});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.mem_req, bus.err, bus.if_stall} !== 3'b011) $display("FAIL wdog_err: got %b expected 011", {bus.mem_req, bus.err, bus.if_stall});
        else pass_cnt++;
        bus.dm_req = 1; bus.mem_ready = 1;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if ({bus.mem_req, bus.err, bus.dm_stall, bus.if_valid, bus.dm_valid} !== 5'b01100)
            $display("FAIL wdog_sticky: got %b expected 01100", {bus.mem_req, bus.err, bus.dm_stall, bus.if_valid, bus.dm_valid});
        else pass_cnt++;
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        total_cnt++;
        if ({bus.mem_req, bus.err} !== 2'b00) $display("FAIL wdog_reset: got %b expected 00", {bus.mem_req, bus.err});
        else pass_cnt++;
        step();
        $display("tx watchdog timeout and reset");
    endtask

    task automatic test_reset_mid();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h60; bus.dm_type = 3'b010;
        step();
        total_cnt++;
        if (bus.mem_req !== 1'b1) $display("FAIL rmid_issue: got %b expected 1", bus.mem_req);
        else pass_cnt++;
        reset = 1; bus.dm_req = 0;
        step();
        reset = 0;
        total_cnt++;
        if ({bus.mem_req, bus.dm_valid} !== 2'b00) $display("FAIL rmid_drop: got %b expected 00", {bus.mem_req, bus.dm_valid});
        else pass_cnt++;
        bus.mem_ready = 1; bus.mem_rdata = 32'h77777777;
        step();
        bus.mem_ready = 0;
        total_cnt++;
        if ({bus.mem_req, bus.dm_valid, bus.if_valid} !== 3'b000 || bus.dm_rdata !== 32'h0)
            $display("FAIL rmid_late_ready: got %b/%h expected 000/00000000", {bus.mem_req, bus.dm_valid, bus.if_valid}, bus.dm_rdata);
        else pass_cnt++;
        step();
        $display("tx reset mid-transaction");
    endtask

    initial begin
        last_if_rdata = '0;
        last_dm_rdata = '0;
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_flush();
        test_store();
        test_watchdog();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
